// File: rtl/acc_job_scheduler.sv
// rtl/acc_job_scheduler.sv - Accelerator job queue and dispatcher between the MIPS core and the data-movement router
//
// Purpose:
//   Buffers up to DEPTH job descriptors posted by the core and dispatches them one
//   at a time to the router. Each dispatched job is completed by the router's level
//   acc_done, by the optional watchdog, or immediately for bypass or zero-size jobs.
//   A one-cycle job_done pulse reports each completion back to the core.
//
// Optional feature:
//   ACC_SCHED_WATCHDOG_EN - when defined, a 16-bit RUN-cycle watchdog ends a job
//   after TIMEOUT cycles and flags it with job_timeout. When undefined, RUN waits
//   for acc_done indefinitely, job_timeout is tied low and TIMEOUT is ignored.
//
// Ports:
//   clk, reset                       clock (rising edge), asynchronous active-low reset
//   job_valid / job_ready            job offer from the core / queue can accept
//   job_instr, job_offset, job_size  job descriptor words
//   job_bypass                       job needs no data movement
//   flush                            drop every queued (not active) job
//   instruction, offset, filesize    active job to the router
//   acc_bypass                       active job bypass flag, 1 while idle
//   acc_start                        one-cycle dispatch strobe
//   acc_done                         level completion from the router
//   job_done, job_timeout            completion pulse and watchdog flag
//   busy                             a job is in flight
//   queue_count                      entries waiting in the queue

module acc_job_scheduler #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 65535
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    job_valid,
   output logic                    job_ready,
   input  logic [31:0]             job_instr,
   input  logic [31:0]             job_offset,
   input  logic [31:0]             job_size,
   input  logic                    job_bypass,
   input  logic                    flush,
   output logic [31:0]             instruction,
   output logic [31:0]             offset,
   output logic [31:0]             filesize,
   output logic                    acc_bypass,
   output logic                    acc_start,
   input  logic                    acc_done,
   output logic                    job_done,
   output logic                    job_timeout,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  queue_count
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, WAIT_LOW} state_t;

   state_t state, state_nxt;

   logic [31:0] q_instr  [DEPTH];
   logic [31:0] q_offset [DEPTH];
   logic [31:0] q_size   [DEPTH];
   logic        q_bypass [DEPTH];

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, push, pop;
   logic          bypass_r;

   assign full        = (count == (AW+1)'(DEPTH));
   assign job_ready   = !full && !flush;
   assign push        = job_valid && job_ready;
   // A flush clears the head as well, so it also suppresses the pop.
   assign pop         = (state == IDLE) && (count != '0) && !flush;
   assign queue_count = count;

   always_ff @(posedge clk) begin
      if (push) begin
         q_instr[wr_ptr]  <= job_instr;
         q_offset[wr_ptr] <= job_offset;
         q_size[wr_ptr]   <= job_size;
         q_bypass[wr_ptr] <= job_bypass;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + (AW+1)'(1);
         else if (pop && !push) count <= count - (AW+1)'(1);
      end
   end

   // Output registers hold the last dispatched job until the next pop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instruction <= '0;
         offset      <= '0;
         filesize    <= '0;
         bypass_r    <= 1'b0;
      end else if (pop) begin
         instruction <= q_instr[rd_ptr];
         offset      <= q_offset[rd_ptr];
         filesize    <= q_size[rd_ptr];
         bypass_r    <= q_bypass[rd_ptr];
      end
   end

`ifdef ACC_SCHED_WATCHDOG_EN
   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   logic [15:0] wdog;
   logic        tmo_flag;
   logic        wd_fire;

   // acc_done has priority over an expiry on the same cycle.
   assign wd_fire = (state == RUN) && !acc_done && (wdog == WD_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wdog     <= '0;
         tmo_flag <= 1'b0;
      end else begin
         if (state == LOAD)     wdog <= '0;
         else if (state == RUN) wdog <= wdog + 16'd1;
         if (state == LOAD)     tmo_flag <= 1'b0;
         else if (wd_fire)      tmo_flag <= 1'b1;
      end
   end

   assign job_timeout = (state == DONE) && tmo_flag;
`else
   logic wd_fire;
   assign wd_fire     = 1'b0;
   assign job_timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      acc_start  = 1'b0;
      job_done   = 1'b0;
      busy       = 1'b1;
      acc_bypass = bypass_r;
      case (state)
         IDLE: begin
            busy       = 1'b0;
            acc_bypass = 1'b1;
            if (pop) state_nxt = LOAD;
         end
         LOAD: begin
            acc_start = 1'b1;
            // Bypass and empty jobs never see acc_done from the router.
            if (bypass_r || (filesize == '0)) state_nxt = DONE;
            else                              state_nxt = RUN;
         end
         RUN: begin
            if (acc_done || wd_fire) state_nxt = DONE;
         end
         DONE: begin
            job_done  = 1'b1;
            state_nxt = acc_done ? WAIT_LOW : IDLE;
         end
         WAIT_LOW: begin
            // A level acc_done still high here belongs to the finished job.
            if (!acc_done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_acc_job_scheduler.sv
// tb/tb_acc_job_scheduler.sv - Randomized scoreboard bench for acc_job_scheduler
`timescale 1ns/1ps
module tb_acc_job_scheduler;

   localparam int DEPTH = 4;
   localparam int TMO   = 8;
`ifdef ACC_SCHED_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] off;
      logic [31:0] size;
      logic        byp;
   } job_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        job_valid, job_ready, job_bypass, flush;
   logic [31:0] job_instr, job_offset, job_size;
   logic [31:0] instruction, offset, filesize;
   logic        acc_bypass, acc_start, acc_done, job_done, job_timeout, busy;
   logic [$clog2(DEPTH):0] queue_count;

   always #5 clk = ~clk;

   acc_job_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .job_valid(job_valid), .job_ready(job_ready),
      .job_instr(job_instr), .job_offset(job_offset), .job_size(job_size),
      .job_bypass(job_bypass), .flush(flush),
      .instruction(instruction), .offset(offset), .filesize(filesize),
      .acc_bypass(acc_bypass), .acc_start(acc_start), .acc_done(acc_done),
      .job_done(job_done), .job_timeout(job_timeout), .busy(busy),
      .queue_count(queue_count)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int now      = 0;

   // Reference: queued jobs plus a timeline (edge numbers) for the active job.
   job_t q[$];
   job_t act, lst;
   bit   act_on = 1'b0;
   bit   tmo    = 1'b0;
   int   s_e = -1, d_e = -1, i_e = -1, ad_hi = 0, ad_lo = 0;
   int   force_d = 0, force_h = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, now);
      end
   endtask

   function automatic job_t mk(input logic [31:0] i, input logic [31:0] o,
                               input logic [31:0] s, input logic b);
      job_t j;
      j.instr = i; j.off = o; j.size = s; j.byp = b;
      return j;
   endfunction

   function automatic job_t rand_job();
      logic [31:0] s;
      s = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 4096));
      return mk($urandom, $urandom, s, ($urandom_range(0, 7) == 0));
   endfunction

   task automatic check_outputs();
      check("acc_start",   32'(acc_start),   32'(act_on && now == s_e));
      check("job_done",    32'(job_done),    32'(act_on && now == d_e));
      check("job_timeout", 32'(job_timeout), 32'(act_on && now == d_e && tmo));
      check("busy",        32'(busy),        32'(act_on));
      check("acc_bypass",  32'(acc_bypass),  32'(act_on ? act.byp : 1'b1));
      check("instruction", instruction,      lst.instr);
      check("offset",      offset,           lst.off);
      check("filesize",    filesize,         lst.size);
      check("queue_count", 32'(queue_count), 32'(q.size()));
      check("job_ready",   32'(job_ready),   32'((q.size() < DEPTH) && !flush));
   endtask

   // Timeline of a job popped at edge e: done edge, idle edge, acc_done window.
   task automatic schedule(input int e);
      int d, h;
      s_e = e; ad_hi = 0; ad_lo = 0; tmo = 1'b0;
      if (act.byp || act.size == 0) begin
         d_e = e + 1;
         i_e = e + 2;
      end else begin
         d = (force_d != 0) ? force_d : int'($urandom_range(1, 12));
         h = (force_h != 0) ? force_h : int'($urandom_range(1, 3));
         if (WD_EN && d > TMO) begin
            tmo = 1'b1;
            d_e = e + 1 + TMO;
            i_e = d_e + 1;
         end else begin
            d_e   = e + 1 + d;
            ad_hi = d_e;
            ad_lo = d_e + h;
            i_e   = ad_lo;
         end
      end
   endtask

   // Called at a falling edge: check, drive the next edge's inputs, advance the model.
   task automatic cycle(input bit v, input job_t j, input bit f);
      int e;
      bit rdy, pp;
      check_outputs();
      e          = now + 1;
      job_valid  = v;
      job_instr  = j.instr;
      job_offset = j.off;
      job_size   = j.size;
      job_bypass = j.byp;
      flush      = f;
      acc_done   = (e >= ad_hi) && (e < ad_lo);
      rdy = (q.size() < DEPTH) && !f;
      pp  = !act_on && (q.size() > 0) && !f;
      if (act_on && e == i_e) act_on = 1'b0;
      if (pp) begin
         act    = q.pop_front();
         lst    = act;
         act_on = 1'b1;
         schedule(e);
      end
      if (f) q.delete();
      if (v && rdy) q.push_back(j);
      @(posedge clk);
      now = e;
      @(negedge clk);
   endtask

   task automatic run_idle(input int n);
      repeat (n) cycle(1'b0, '0, 1'b0);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b0; job_valid = 1'b0; flush = 1'b0; acc_done = 1'b0;
      #1;
      q.delete(); act_on = 1'b0; lst = '0; ad_hi = 0; ad_lo = 0;
      check_outputs();
      repeat (n) begin
         @(posedge clk);
         now++;
         @(negedge clk);
         check_outputs();
      end
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; job_valid = 1'b0; flush = 1'b0; acc_done = 1'b0;
      job_instr = '0; job_offset = '0; job_size = '0; job_bypass = 1'b0;
      lst = '0; act = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_outputs();
      reset = 1'b1;

      // Single job, acc_done 5 cycles into RUN, drops during DONE.
      force_d = 5; force_h = 1;
      cycle(1'b1, mk(32'h1, 32'h100, 32'd16, 1'b0), 1'b0);
      run_idle(15);

      // Overfill while the first job is stalled; FIFO order through the model.
      force_d = 12; force_h = 0;
      for (int i = 0; i < DEPTH + 2; i++)
         cycle(1'b1, mk(32'h10 + 32'(i), 32'h2000 + 32'(i), 32'd64, 1'b0), 1'b0);
      run_idle(120);

      // Watchdog: acc_done never arrives within TIMEOUT (when built in).
      force_d = 20;
      cycle(1'b1, mk(32'h30, 32'h300, 32'd8, 1'b0), 1'b0);
      cycle(1'b1, mk(32'h31, 32'h310, 32'd8, 1'b0), 1'b0);
      run_idle(60);

      // Exact tie: acc_done on the last watchdog cycle wins.
      force_d = TMO;
      cycle(1'b1, mk(32'h38, 32'h380, 32'd4, 1'b0), 1'b0);
      run_idle(20);

      // Zero-size and bypass jobs need no acc_done.
      force_d = 0;
      cycle(1'b1, mk(32'h40, 32'h400, 32'd0, 1'b0), 1'b0);
      cycle(1'b1, mk(32'h41, 32'h410, 32'd5, 1'b1), 1'b0);
      run_idle(10);

      // acc_done held high across DONE keeps the next job waiting.
      force_d = 2; force_h = 5;
      cycle(1'b1, mk(32'h50, 32'h500, 32'd9, 1'b0), 1'b0);
      cycle(1'b1, mk(32'h51, 32'h510, 32'd9, 1'b0), 1'b0);
      run_idle(30);

      // Flush together with a push.
      force_d = 10; force_h = 0;
      for (int i = 0; i < 3; i++)
         cycle(1'b1, mk(32'h60 + 32'(i), 32'h600, 32'd3, 1'b0), 1'b0);
      cycle(1'b1, mk(32'h6f, 32'h6f0, 32'd3, 1'b0), 1'b1);
      run_idle(30);

      // Reset mid-RUN with two jobs still queued.
      force_d = 12;
      for (int i = 0; i < 3; i++)
         cycle(1'b1, mk(32'h70 + 32'(i), 32'h700, 32'd7, 1'b0), 1'b0);
      run_idle(3);
      do_reset(3);
      force_d = 0;
      run_idle(5);

      // Random traffic.
      repeat (1500) begin
         bit v, f;
         v = ($urandom_range(0, 9) < 3);
         f = ($urandom_range(0, 63) == 0);
         cycle(v, rand_job(), f);
      end
      run_idle(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
